tile_bank: RTL

TILE_BANK -- requirements
Module: tile_bank

---
 rtl/tile_pkg.sv | 49 ++++
 rtl/tile_slot.sv | 69 ++++++
 rtl/tile_bank.sv | 80 ++++++++
 3 files changed

// File: rtl/tile_pkg.sv
// Shared field layout, address map and helpers for the tile bank.
package tile_pkg;

   localparam int unsigned ADDR_W           = 5;
   localparam int unsigned COORD_W          = 10;
   localparam int unsigned SCREEN_H_DEFAULT = 480;

   // Tile word layout; bit 31 is reserved and never stored.
   localparam int unsigned TOP_X_LSB  = 0;
   localparam int unsigned TOP_Y_LSB  = 10;
   localparam int unsigned LENGTH_LSB = 20;
   localparam int unsigned ENABLE_BIT = 30;

   // Control register layout; it lives at the address just past the last slot.
   localparam int unsigned CTRL_WIDTH_LSB = 0;
   localparam int unsigned CTRL_STEP_LSB  = 10;
   localparam int unsigned CTRL_AUTO_BIT  = 20;

   typedef struct packed {
      logic               enable;
      logic [COORD_W-1:0] length;
      logic [COORD_W-1:0] top_y;
      logic [COORD_W-1:0] top_x;
   } tile_t;

   typedef struct packed {
      logic               auto_scroll;
      logic [COORD_W-1:0] step;
      logic [COORD_W-1:0] width;
   } ctrl_t;

   function automatic tile_t decode_tile(input logic [30:0] word);
      tile_t t;
      t.top_x  = word[TOP_X_LSB  +: COORD_W];
      t.top_y  = word[TOP_Y_LSB  +: COORD_W];
      t.length = word[LENGTH_LSB +: COORD_W];
      t.enable = word[ENABLE_BIT];
      return t;
   endfunction

   function automatic ctrl_t decode_ctrl(input logic [20:0] word);
      ctrl_t c;
      c.width       = word[CTRL_WIDTH_LSB +: COORD_W];
      c.step        = word[CTRL_STEP_LSB  +: COORD_W];
      c.auto_scroll = word[CTRL_AUTO_BIT];
      return c;
   endfunction

endpackage

// File: rtl/tile_slot.sv
// One tile slot: shadow/active registers, auto-scroll with wrap pulse, and hit compare.
module tile_slot
   import tile_pkg::*;
#(
   parameter int unsigned SCREEN_H = SCREEN_H_DEFAULT
) (
   input  logic               clk,
   input  logic               res,
   input  logic               wr,
   input  tile_t              wdata,
   input  logic               animate,
   input  logic [COORD_W-1:0] width,
   input  logic [COORD_W-1:0] step,
   input  logic               auto_scroll,
   input  logic [9:0]         x,
   input  logic [8:0]         y,
   output logic               hit,
   output logic               wrap
);

   tile_t       shadow;
   tile_t       active;
   logic        dirty;
   logic [10:0] scroll_sum;
   logic [10:0] y_end;
   logic [10:0] x_end;

   always_comb begin
      scroll_sum = {1'b0, active.top_y} + {1'b0, step};
      y_end      = {1'b0, active.top_y} + {1'b0, active.length};
      x_end      = {1'b0, active.top_x} + {1'b0, width};
      hit        = active.enable
                   && ({2'b00, y} > {1'b0, active.top_y})
                   && ({2'b00, y} < y_end)
                   && ({1'b0, x}  > {1'b0, active.top_x})
                   && ({1'b0, x}  < x_end);
   end

   // The write is applied after the commit so a coinciding write stays dirty
   // while the commit still takes the pre-write shadow.
   always_ff @(posedge clk) begin
      if (res) begin
         shadow <= '0;
         active <= '0;
         dirty  <= 1'b0;
         wrap   <= 1'b0;
      end else begin
         wrap <= 1'b0;
         if (animate) begin
            if (dirty) begin
               active <= shadow;
               dirty  <= 1'b0;
            end else if (auto_scroll && active.enable) begin
               if (scroll_sum >= 11'(SCREEN_H)) begin
                  active.top_y <= 10'(scroll_sum - 11'(SCREEN_H));
                  wrap         <= 1'b1;
               end else begin
                  active.top_y <= scroll_sum[9:0];
               end
            end
         end
         if (wr) begin
            shadow <= wdata;
            dirty  <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/tile_bank.sv
// Bank of tile slots with bus-written control, priority-encoded registered hit output.
module tile_bank
   import tile_pkg::*;
#(
   parameter int unsigned NUM_TILES = 4,
   parameter int unsigned SCREEN_H  = SCREEN_H_DEFAULT
) (
   input  logic                 clk,
   input  logic                 res,
   input  logic                 write_en,
   input  logic [ADDR_W-1:0]    addr,
   input  logic [31:0]          pwdata,
   input  logic                 animate,
   input  logic [9:0]           x,
   input  logic [8:0]           y,
   output logic                 hit,
   output logic [3:0]           hit_idx,
   output logic [NUM_TILES-1:0] wrap
);

   ctrl_t                ctrl;
   tile_t                wdata;
   logic [NUM_TILES-1:0] slot_hit;
   logic                 any_hit;
   logic [3:0]           first_idx;
   logic                 unused_msb;

   assign wdata      = decode_tile(pwdata[30:0]);
   assign unused_msb = pwdata[31];

   for (genvar i = 0; i < NUM_TILES; i++) begin : g_slot
      tile_slot #(
         .SCREEN_H(SCREEN_H)
      ) u_slot (
         .clk        (clk),
         .res        (res),
         .wr         (write_en && (addr == ADDR_W'(i))),
         .wdata      (wdata),
         .animate    (animate),
         .width      (ctrl.width),
         .step       (ctrl.step),
         .auto_scroll(ctrl.auto_scroll),
         .x          (x),
         .y          (y),
         .hit        (slot_hit[i]),
         .wrap       (wrap[i])
      );
   end

   always_ff @(posedge clk) begin
      if (res) begin
         ctrl <= '0;
      end else if (write_en && (addr == ADDR_W'(NUM_TILES))) begin
         ctrl <= decode_ctrl(pwdata[20:0]);
      end
   end

   // Scan from the top so the lowest hitting slot is the last one assigned.
   always_comb begin
      any_hit   = 1'b0;
      first_idx = '0;
      for (int unsigned i = NUM_TILES; i > 0; i--) begin
         if (slot_hit[i-1]) begin
            any_hit   = 1'b1;
            first_idx = 4'(i - 1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (res) begin
         hit     <= 1'b0;
         hit_idx <= '0;
      end else begin
         hit     <= any_hit;
         hit_idx <= first_idx;
      end
   end

endmodule
